// File: rtl/arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// FSM encoding is fixed so waveforms and debug scripts decode it consistently.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

    localparam int DEF_N_CORES = 4;
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_ADDR_W  = 12;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select: lowest requesting index at or after ptr, wrapping.
// Purely combinational; no backpressure, the caller decides when to sample.
module rr_picker #(
    parameter int N_CORES = 4,
    parameter int PTR_W   = 2
) (
    input  logic [N_CORES-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_CORES-1:0] win,
    output logic [PTR_W-1:0]   win_idx
);

    logic found;
    int   idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = (int'(ptr) + k) % N_CORES;
            if (!found && req[idx]) begin
                found        = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single-port data memory between cores, one access at a time, round-robin.
// Grant/strobe 1 cycle after a request is seen idle, read data 1 cycle later; requesters hold until granted.
module mem_access_arbiter
    import arb_pkg::*;
#(
    parameter int N_CORES = DEF_N_CORES,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_we,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    input  logic [N_CORES-1:0]          core_done,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [N_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        end_process
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic               we_q;
    logic [N_CORES-1:0] done_q;

    logic [N_CORES-1:0] win;
    logic [PTR_W-1:0]   win_idx;
    logic               req_any;

    logic [N_CORES-1:0] gnt_d;
    logic [N_CORES-1:0] rvalid_d;
    logic               mem_en_d;
    logic               mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;

    assign req_any = |core_req;

    rr_picker #(
        .N_CORES (N_CORES),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (core_req),
        .ptr     (rr_ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? IDLE : RDWAIT;
            RDWAIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs: the ISSUE-cycle strobes are
    // loaded on the IDLE->ISSUE edge so they appear exactly during ISSUE.
    always_comb begin
        gnt_d       = '0;
        rvalid_d    = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (req_any) begin
                    gnt_d       = win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = core_we[win_idx];
                    mem_addr_d  = core_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d = core_wdata[int'(win_idx)*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                if (!we_q) rvalid_d[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_gnt    <= '0;
            core_rvalid <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            core_gnt    <= gnt_d;
            core_rvalid <= rvalid_d;
            mem_en      <= mem_en_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= '0;
            we_q   <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                owner <= win_idx;
                we_q  <= core_we[win_idx];
            end
            if (state == ISSUE) begin
                rr_ptr <= (owner == PTR_W'(N_CORES-1)) ? '0 : owner + 1'b1;
            end
        end
    end

    // Completion is only declared once no access is pending or in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= '0;
            end_process <= 1'b0;
        end else begin
            done_q <= done_q | core_done;
            if (&done_q && state == IDLE && !req_any) begin
                end_process <= 1'b1;
            end
        end
    end

    assign core_rdata = (|core_rvalid) ? mem_rdata : '0;

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Round-robin arbiter that shares the single-port data memory between the processing cores of the multi-core matrix processor. It sequences one memory access at a time over a request/grant handshake and returns read data to the owning core. It also collects per-core completion flags and raises `end_process`, which the top level uses to signal that results `r1`..`r4` are final. It sits between the core array and the data memory inside `top`.

## Interface
Parameters:
- `N_CORES`, 4, number of requesters
- `DATA_W`, 12, memory data width (matches result register width)
- `ADDR_W`, 12, memory address width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `core_req`  in  N_CORES  per-core access request
- `core_we`  in  N_CORES  per-core write enable (1 = write, 0 = read)
- `core_addr`  in  N_CORES*ADDR_W  packed addresses, core i at `[i*ADDR_W +: ADDR_W]`
- `core_wdata`  in  N_CORES*DATA_W  packed write data, same packing
- `core_done`  in  N_CORES  core has finished its program (level)
- `core_gnt`  out  N_CORES  one-hot, one-cycle grant pulse
- `core_rvalid`  out  N_CORES  one-hot, one-cycle read-data-valid pulse
- `core_rdata`  out  DATA_W  read data, broadcast to all cores, qualified by `core_rvalid`
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_en && !mem_we`
- `end_process`  out  1  all cores done and arbiter idle; sticky until reset

## Operation
- States: IDLE, ISSUE, RDWAIT.
- IDLE: if any `core_req` bit is set, pick a winner by round-robin starting at `rr_ptr`. Latch owner, we, addr, wdata. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: assert `core_gnt[owner]`, `mem_en`, and `mem_we` = latched we, with latched addr/wdata. Set `rr_ptr` = (owner+1) mod N_CORES. Write goes to IDLE; read goes to RDWAIT.
- RDWAIT: `core_rvalid[owner]`=1, `core_rdata`=`mem_rdata`. Go to IDLE.
- `core_req` is sampled only in IDLE. A requester holds req/we/addr/wdata stable until it sees `core_gnt`. If req is still high in the cycle after gnt, that is a new request.
- Only one grant can be outstanding at a time. No request is ever dropped. Starvation bound: a waiting core is granted within N_CORES arbitrations.
- `done_q[i]` is set sticky when `core_done[i]`=1. `end_process` is set when all `done_q` bits are 1, state is IDLE, and `core_req`=0. Once set, it stays 1 until reset.
- Reset values: `core_gnt`, `core_rvalid`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `core_rdata` = 0; `end_process` = 0; `rr_ptr` = 0; `done_q` = 0; state = IDLE.
- Reset mid-operation: an in-flight read is abandoned (no `core_rvalid`). An in-flight write is not guaranteed to complete.

## Timing
- Request seen in IDLE at cycle t: grant and memory strobe at t+1; read data valid at t+2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- All `mem_*` outputs and `core_gnt` are registered. `core_rdata` is combinational from `mem_rdata`, registered `core_rvalid`.
- Simultaneous requests: the winner is the lowest index ≥ `rr_ptr`, wrapping around.
- `core_done` rising in the same cycle as the last request: `end_process` waits until that access completes and the FSM returns to IDLE.

## Structure
- Package `arb_pkg`: state enum (IDLE=2'd0, ISSUE=2'd1, RDWAIT=2'd2), default `N_CORES`, `DATA_W`, `ADDR_W`.
- Sub-module `rr_picker`: combinational, takes `req[N_CORES]` and `ptr`, returns a one-hot `win` plus `win_idx`. Instantiated once.
- Top FSM, latch registers, and done tracking live in `mem_access_arbiter`.

## Test plan
- Single read: core 2 reads addr 0x010 (memory holds 0x5A3). Required: `core_gnt[2]` at t+1, `core_rvalid[2]` with `core_rdata`=0x5A3 at t+2.
- All four request at once, all writes (addr = i, data = 0x100+i), `rr_ptr`=0. Required: grants in order 0,1,2,3, each 2 cycles apart; memory then holds 0x100..0x103.
- Fairness: cores 0 and 3 hold req continuously for 8 arbitrations. Required: grants alternate 0,3,0,3…; no core gets two consecutive grants while the other waits.
- Completion: done bits assert in order 1,0,3,2, with a core 2 write still in flight. Required: `end_process` rises only after that write's ISSUE cycle and return to IDLE, then stays 1.
- Reset during RDWAIT of a core 1 read. Required: no `core_rvalid`; all outputs 0 on the next edge; after reset release, the first grant goes to core 0 when all cores request.
